// File: rtl/ex_muldiv_unit_pkg.sv
// ----------------------------------------------------------------------------
// ex_muldiv_unit_pkg
// Shared types for the EX-stage multiply/divide unit.
//   muldiv_op_e    : M-extension op, encoded as funct3 of OP / OP-32
//   muldiv_state_e : iteration FSM states
//   MULDIV_XLEN    : datapath width (RV64)
//   op_is_div()    : funct3[2] separates divide/remainder from multiply
// ----------------------------------------------------------------------------
package ex_muldiv_unit_pkg;

    localparam int MULDIV_XLEN = 64;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } muldiv_state_e;

    function automatic logic op_is_div(input logic [2:0] op);
        return op[2];
    endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// ----------------------------------------------------------------------------
// muldiv_sign_fix
// Combinational result formatting for the FIX state of ex_muldiv_unit:
// negates the magnitude result, selects the product half or the
// quotient/remainder, and sign-extends bit 31 for *W ops.
// Ports:
//   acc     in  2*XLEN  accumulator: product, or {remainder, quotient}
//   is_div  in  1       divide/remainder op
//   sel_hi  in  1       take the high product half (MULH*)
//   sel_rem in  1       take the remainder (REM*)
//   word    in  1       *W op
//   neg     in  1       result must be negated
//   result  out XLEN    formatted result
// ----------------------------------------------------------------------------
module muldiv_sign_fix #(
    parameter int XLEN = 64
) (
    input  logic [2*XLEN-1:0] acc,
    input  logic              is_div,
    input  logic              sel_hi,
    input  logic              sel_rem,
    input  logic              word,
    input  logic              neg,
    output logic [XLEN-1:0]   result
);

    logic [2*XLEN-1:0] prod;
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   qr;
    logic [XLEN-1:0]   qr_s;
    logic [XLEN-1:0]   val;

    always_comb begin
        // A *W multiply runs 32 iterations, which leaves the product
        // shifted up by XLEN-32 bits in the accumulator.
        prod   = word ? (acc >> (XLEN - 32)) : acc;
        prod_s = neg ? -prod : prod;
        qr     = sel_rem ? acc[2*XLEN-1:XLEN] : acc[XLEN-1:0];
        qr_s   = neg ? -qr : qr;
        if (is_div) begin
            val = qr_s;
        end else begin
            val = sel_hi ? prod_s[2*XLEN-1:XLEN] : prod_s[XLEN-1:0];
        end
        result = word ? {{(XLEN-32){val[31]}}, val[31:0]} : val;
    end

endmodule

// File: rtl/ex_muldiv_unit.sv
// ----------------------------------------------------------------------------
// ex_muldiv_unit
// Iterative RV64M multiply/divide unit in the EX stage. Multiplies by
// shift-add and divides by restoring division on operand magnitudes, one
// bit per cycle, then sign-corrects in FIX. Holds the upstream pipeline
// via stall_o while busy and pulses done_o for one cycle with the result.
// Optional build macro: MULDIV_FAST_MUL_EN -- multiplies use a single
// XLEN x XLEN product in one CALC cycle; divide is unchanged.
// Ports:
//   clk       in   1     clock
//   rst       in   1     asynchronous reset, active low
//   start_i   in   1     valid M-extension op in ID/EX
//   op_i      in   3     muldiv_op_e (funct3)
//   word_i    in   1     *W variant
//   rs1_i     in   XLEN  multiplicand / dividend
//   rs2_i     in   XLEN  multiplier / divisor
//   flush_i   in   1     abort any op in flight
//   stall_o   out  1     hold upstream pipeline registers
//   done_o    out  1     one-cycle result-valid pulse
//   result_o  out  XLEN  result, held until the next completion
// ----------------------------------------------------------------------------
module ex_muldiv_unit
    import ex_muldiv_unit_pkg::*;
#(
    parameter int XLEN  = MULDIV_XLEN,
    parameter int CNT_W = 7
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic [2:0]      op_i,
    input  logic            word_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    input  logic            flush_i,
    output logic            stall_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    muldiv_state_e     state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  load_cnt;
    logic [2*XLEN-1:0] acc_q;
    logic [XLEN-1:0]   opnd_q;
    logic [2:0]        op_q;
    logic              word_q;
    logic              neg_q;

    muldiv_op_e        op_in;
    logic              a_sgn, b_sgn, sa, sb;
    logic              div_in, div0, ovf, shortcut, accept, res_neg;
    logic [XLEN-1:0]   a_ext, b_ext, a_mag, b_mag, min_val;
    logic [XLEN:0]     div_rem, div_try;
    logic [2*XLEN-1:0] div_nxt, calc_nxt;
    logic [XLEN-1:0]   fix_result;

    // Operand decode for the acceptance cycle: extend, take magnitudes,
    // detect the divide shortcuts.
    always_comb begin
        op_in   = muldiv_op_e'(op_i);
        div_in  = op_is_div(op_i);
        a_sgn   = (op_in == OP_MULH) || (op_in == OP_MULHSU) ||
                  (op_in == OP_DIV)  || (op_in == OP_REM);
        b_sgn   = (op_in == OP_MULH) || (op_in == OP_DIV) || (op_in == OP_REM);
        if (word_i) begin
            a_ext   = {{(XLEN-32){a_sgn & rs1_i[31]}}, rs1_i[31:0]};
            b_ext   = {{(XLEN-32){b_sgn & rs2_i[31]}}, rs2_i[31:0]};
            min_val = {{(XLEN-31){1'b1}}, 31'b0};
        end else begin
            a_ext   = rs1_i;
            b_ext   = rs2_i;
            min_val = {1'b1, {(XLEN-1){1'b0}}};
        end
        sa       = a_sgn & a_ext[XLEN-1];
        sb       = b_sgn & b_ext[XLEN-1];
        a_mag    = sa ? -a_ext : a_ext;
        b_mag    = sb ? -b_ext : b_ext;
        div0     = div_in && (b_ext == '0);
        ovf      = div_in && a_sgn && (a_ext == min_val) && (b_ext == '1);
        shortcut = div0 || ovf;
        // Remainder follows the dividend; everything else uses sa ^ sb.
        res_neg  = (op_in == OP_REM) ? sa : (sa ^ sb);
        accept   = (state_q == ST_IDLE) && start_i && !flush_i;
`ifdef MULDIV_FAST_MUL_EN
        load_cnt = div_in ? (word_i ? CNT_W'(32) : CNT_W'(XLEN)) : CNT_W'(1);
`else
        load_cnt = word_i ? CNT_W'(32) : CNT_W'(XLEN);
`endif
    end

    // One CALC iteration. Restoring divide: shift left, trial-subtract the
    // divisor from the widened partial remainder, keep it if non-negative.
    always_comb begin
        div_rem = acc_q[2*XLEN-1:XLEN-1];
        div_try = div_rem - {1'b0, opnd_q};
        div_nxt = div_try[XLEN] ? {div_rem[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                : {div_try[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    end

`ifdef MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] fast_prod;

    always_comb begin
        fast_prod = {{XLEN{1'b0}}, opnd_q} * {{XLEN{1'b0}}, acc_q[XLEN-1:0]};
        // Align *W products like the iterative path so FIX is shared.
        calc_nxt  = op_q[2] ? div_nxt
                            : (word_q ? (fast_prod << (XLEN - 32)) : fast_prod);
    end
`else
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_nxt;

    // Shift-add: add the multiplicand into the high half when the current
    // multiplier bit (acc[0]) is set, then shift the whole accumulator right.
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} +
                   (acc_q[0] ? {1'b0, opnd_q} : {(XLEN+1){1'b0}});
        mul_nxt  = {mul_sum, acc_q[XLEN-1:1]};
        calc_nxt = op_q[2] ? div_nxt : mul_nxt;
    end
`endif

    // Next state and handshake outputs.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (start_i) state_d = shortcut ? ST_FIX : ST_CALC;
            ST_CALC: if (cnt_q == CNT_W'(1)) state_d = ST_FIX;
            ST_FIX:  state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (flush_i) state_d = ST_IDLE;
        stall_o = ((state_q == ST_IDLE) && start_i && !flush_i) ||
                  (state_q == ST_CALC) || (state_q == ST_FIX);
        done_o  = (state_q == ST_DONE) && !flush_i;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            result_o <= '0;
        end else begin
            state_q <= state_d;
            if (flush_i) begin
                cnt_q <= '0;
            end else if (accept) begin
                cnt_q <= shortcut ? '0 : load_cnt;
            end else if (state_q == ST_CALC) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
            if ((state_q == ST_FIX) && !flush_i) begin
                result_o <= fix_result;
            end
        end
    end

    // Datapath registers are only meaningful after an accept, so they carry
    // no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_q   <= op_i;
            word_q <= word_i;
            neg_q  <= shortcut ? 1'b0 : res_neg;
            opnd_q <= div_in ? b_mag : a_mag;
            if (div0) begin
                acc_q <= {a_ext, {XLEN{1'b1}}};
            end else if (ovf) begin
                acc_q <= {{XLEN{1'b0}}, a_ext};
            end else if (div_in) begin
                // *W dividends start at the top of the low half so that
                // 32 iterations consume all of them.
                acc_q <= {{XLEN{1'b0}},
                          (word_i ? (a_mag << (XLEN - 32)) : a_mag)};
            end else begin
                acc_q <= {{XLEN{1'b0}}, b_mag};
            end
        end else if (state_q == ST_CALC) begin
            acc_q <= calc_nxt;
        end
    end

    muldiv_sign_fix #(
        .XLEN(XLEN)
    ) u_sign_fix (
        .acc    (acc_q),
        .is_div (op_q[2]),
        .sel_hi (!op_q[2] && (op_q[1:0] != 2'b00)),
        .sel_rem(op_q[2] && op_q[1]),
        .word   (word_q),
        .neg    (neg_q),
        .result (fix_result)
    );

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// ----------------------------------------------------------------------------
// tb_ex_muldiv_unit
// Self-checking bench for ex_muldiv_unit. Expected results and latencies
// are pushed to a scoreboard queue when an op is issued and popped when
// done_o fires.
// ----------------------------------------------------------------------------
module tb_ex_muldiv_unit;
    import ex_muldiv_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start_i = 1'b0;
    logic [2:0]  op_i = 3'b000;
    logic        word_i = 1'b0;
    logic [63:0] rs1_i = '0;
    logic [63:0] rs2_i = '0;
    logic        flush_i = 1'b0;
    logic        stall_o;
    logic        done_o;
    logic [63:0] result_o;

    always #5 clk = ~clk;

    ex_muldiv_unit dut (
        .clk     (clk),
        .rst     (rst),
        .start_i (start_i),
        .op_i    (op_i),
        .word_i  (word_i),
        .rs1_i   (rs1_i),
        .rs2_i   (rs2_i),
        .flush_i (flush_i),
        .stall_o (stall_o),
        .done_o  (done_o),
        .result_o(result_o)
    );

    typedef struct {
        logic [63:0] res;
        int          lat;
    } exp_t;

    typedef struct {
        string       name;
        logic [2:0]  op;
        bit          w;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] r;
        int          lat;
    } vec_t;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [63:0] last_res = '0;

    function automatic int mul_lat(input bit w);
`ifdef MULDIV_FAST_MUL_EN
        return 3;
`else
        return w ? 34 : 66;
`endif
    endfunction

    task automatic issue(input logic [2:0] op, input bit w, input logic [63:0] a,
                         input logic [63:0] b, input logic [63:0] r, input int lat);
        @(negedge clk);
        start_i = 1'b1;
        op_i    = op;
        word_i  = w;
        rs1_i   = a;
        rs2_i   = b;
        sb_q.push_back('{res: r, lat: lat});
    endtask

    // Called in the issue cycle; returns the result at done_o, the cycle it
    // arrived in (-1 if never), and whether stall_o had the required shape.
    task automatic wait_done(output logic [63:0] res, output int lat, output bit stall_ok);
        stall_ok = 1'b1;
        lat      = -1;
        res      = 'x;
        #1;
        if (stall_o !== 1'b1) stall_ok = 1'b0;
        @(posedge clk);
        #1 start_i = 1'b0;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            if (done_o === 1'b1) begin
                res = result_o;
                lat = k;
                if (stall_o !== 1'b0) stall_ok = 1'b0;
                break;
            end
            if (stall_o !== 1'b1) stall_ok = 1'b0;
        end
    endtask

    task automatic test_reset();
        #12;
        n_checks++; if (stall_o !== 1'b0) $display("FAIL reset_stall got=%b exp=0", stall_o); else n_pass++;
        n_checks++; if (done_o !== 1'b0) $display("FAIL reset_done got=%b exp=0", done_o); else n_pass++;
        n_checks++; if (result_o !== 64'd0) $display("FAIL reset_result got=%h exp=0", result_o); else n_pass++;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_mul();
        vec_t v[5];
        logic [63:0] got; int lat; bit st; exp_t e;
        v = '{
            '{"mul_7_x_m3",   OP_MUL,    1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, mul_lat(0)},
            '{"mulhu_max_x2", OP_MULHU,  1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'd1, mul_lat(0)},
            '{"mulh_m1_x_m1", OP_MULH,   1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, mul_lat(0)},
            '{"mulhsu_m2_x3", OP_MULHSU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 64'd3, 64'hFFFF_FFFF_FFFF_FFFF, mul_lat(0)},
            '{"mulh_2p62_x4", OP_MULH,   1'b0, 64'h4000_0000_0000_0000, 64'd4, 64'd1, mul_lat(0)}
        };
        foreach (v[i]) begin
            issue(v[i].op, v[i].w, v[i].a, v[i].b, v[i].r, v[i].lat);
            wait_done(got, lat, st);
            e = sb_q.pop_front();
            n_checks++; if (got !== e.res) $display("FAIL %s result got=%h exp=%h", v[i].name, got, e.res); else n_pass++;
            n_checks++; if (lat != e.lat) $display("FAIL %s latency got=%0d exp=%0d", v[i].name, lat, e.lat); else n_pass++;
            n_checks++; if (!st) $display("FAIL %s stall_shape got=bad exp=1_until_FIX_0_in_DONE", v[i].name); else n_pass++;
            last_res = e.res;
        end
    endtask

    task automatic test_div();
        vec_t v[6];
        logic [63:0] got; int lat; bit st; exp_t e;
        v = '{
            '{"div_m7_2",   OP_DIV,  1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 66},
            '{"rem_m7_2",   OP_REM,  1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 66},
            '{"divu_100_7", OP_DIVU, 1'b0, 64'd100, 64'd7, 64'd14, 66},
            '{"remu_100_7", OP_REMU, 1'b0, 64'd100, 64'd7, 64'd2, 66},
            '{"rem_7_m2",   OP_REM,  1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 66},
            '{"div_7_m2",   OP_DIV,  1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFD, 66}
        };
        foreach (v[i]) begin
            issue(v[i].op, v[i].w, v[i].a, v[i].b, v[i].r, v[i].lat);
            wait_done(got, lat, st);
            e = sb_q.pop_front();
            n_checks++; if (got !== e.res) $display("FAIL %s result got=%h exp=%h", v[i].name, got, e.res); else n_pass++;
            n_checks++; if (lat != e.lat) $display("FAIL %s latency got=%0d exp=%0d", v[i].name, lat, e.lat); else n_pass++;
            n_checks++; if (!st) $display("FAIL %s stall_shape got=bad exp=1_until_FIX_0_in_DONE", v[i].name); else n_pass++;
            last_res = e.res;
        end
    endtask

    task automatic test_shortcut();
        vec_t v[5];
        logic [63:0] got; int lat; bit st; exp_t e;
        v = '{
            '{"div_by_zero",  OP_DIV,  1'b0, 64'd123, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 2},
            '{"rem_5_by_0",   OP_REM,  1'b0, 64'd5, 64'd0, 64'd5, 2},
            '{"div_ovf",      OP_DIV,  1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 2},
            '{"rem_ovf",      OP_REM,  1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 2},
            '{"divu_min_max", OP_DIVU, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 66}
        };
        foreach (v[i]) begin
            issue(v[i].op, v[i].w, v[i].a, v[i].b, v[i].r, v[i].lat);
            wait_done(got, lat, st);
            e = sb_q.pop_front();
            n_checks++; if (got !== e.res) $display("FAIL %s result got=%h exp=%h", v[i].name, got, e.res); else n_pass++;
            n_checks++; if (lat != e.lat) $display("FAIL %s latency got=%0d exp=%0d", v[i].name, lat, e.lat); else n_pass++;
            n_checks++; if (!st) $display("FAIL %s stall_shape got=bad exp=1_until_FIX_0_in_DONE", v[i].name); else n_pass++;
            last_res = e.res;
        end
    endtask

    task automatic test_word();
        vec_t v[5];
        logic [63:0] got; int lat; bit st; exp_t e;
        v = '{
            '{"divw_lo7_2",   OP_DIV,  1'b1, 64'h1_0000_0007, 64'd2, 64'd3, 34},
            '{"mulw_max_x2",  OP_MUL,  1'b1, 64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, mul_lat(1)},
            '{"remuw_ff_16",  OP_REMU, 1'b1, 64'hFFFF_FFFF, 64'd16, 64'd15, 34},
            '{"divuw_ff_1",   OP_DIVU, 1'b1, 64'hFFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 34},
            '{"divw_by_lo0",  OP_DIV,  1'b1, 64'd5, 64'h1_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 2}
        };
        foreach (v[i]) begin
            issue(v[i].op, v[i].w, v[i].a, v[i].b, v[i].r, v[i].lat);
            wait_done(got, lat, st);
            e = sb_q.pop_front();
            n_checks++; if (got !== e.res) $display("FAIL %s result got=%h exp=%h", v[i].name, got, e.res); else n_pass++;
            n_checks++; if (lat != e.lat) $display("FAIL %s latency got=%0d exp=%0d", v[i].name, lat, e.lat); else n_pass++;
            n_checks++; if (!st) $display("FAIL %s stall_shape got=bad exp=1_until_FIX_0_in_DONE", v[i].name); else n_pass++;
            last_res = e.res;
        end
    endtask

    task automatic test_flush();
        bit seen_done = 1'b0;
        @(negedge clk);
        start_i = 1'b1; op_i = OP_DIV; word_i = 1'b0; rs1_i = 64'd1000; rs2_i = 64'd3;
        @(posedge clk);
        #1 start_i = 1'b0;
        for (int k = 1; k <= 10; k++) @(negedge clk);
        flush_i = 1'b1;
        @(posedge clk);
        #1 flush_i = 1'b0;
        @(negedge clk);
        n_checks++; if (stall_o !== 1'b0) $display("FAIL flush_stall got=%b exp=0", stall_o); else n_pass++;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            if (done_o !== 1'b0) seen_done = 1'b1;
        end
        n_checks++; if (seen_done) $display("FAIL flush_no_done got=pulse exp=none"); else n_pass++;
        n_checks++; if (result_o !== last_res) $display("FAIL flush_result_held got=%h exp=%h", result_o, last_res); else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic [63:0] got; int lat; bit st; exp_t e;
        issue(OP_MUL, 1'b0, 64'd9, 64'd9, 64'd81, mul_lat(0));
        @(posedge clk);
        #1 start_i = 1'b0;
        repeat (20) @(negedge clk);
        rst = 1'b0;
        #1;
        void'(sb_q.pop_back());
        n_checks++; if (stall_o !== 1'b0) $display("FAIL rstmid_stall got=%b exp=0", stall_o); else n_pass++;
        n_checks++; if (done_o !== 1'b0) $display("FAIL rstmid_done got=%b exp=0", done_o); else n_pass++;
        n_checks++; if (result_o !== 64'd0) $display("FAIL rstmid_result got=%h exp=0", result_o); else n_pass++;
        @(negedge clk);
        rst = 1'b1;
        issue(OP_DIVU, 1'b0, 64'd100, 64'd7, 64'd14, 66);
        wait_done(got, lat, st);
        e = sb_q.pop_front();
        n_checks++; if (got !== e.res) $display("FAIL rstmid_after result got=%h exp=%h", got, e.res); else n_pass++;
        n_checks++; if (lat != e.lat) $display("FAIL rstmid_after latency got=%0d exp=%0d", lat, e.lat); else n_pass++;
        @(negedge clk);
        n_checks++; if (done_o !== 1'b0) $display("FAIL done_single_cycle got=%b exp=0", done_o); else n_pass++;
        n_checks++; if (result_o !== e.res) $display("FAIL result_held got=%h exp=%h", result_o, e.res); else n_pass++;
        last_res = e.res;
    endtask

    // start_i held high across DONE: the DONE-cycle start must be ignored
    // and the following IDLE cycle accepts the new operands.
    task automatic test_back_to_back();
        int   n_done = 0;
        exp_t e;
        @(negedge clk);
        start_i = 1'b1; op_i = OP_REM; word_i = 1'b0; rs1_i = 64'd5; rs2_i = 64'd0;
        sb_q.push_back('{res: 64'd5, lat: 2});
        sb_q.push_back('{res: 64'd9, lat: 5});
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (done_o === 1'b1) begin
                n_done++;
                if (sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    n_checks++; if (result_o !== e.res) $display("FAIL b2b_result got=%h exp=%h", result_o, e.res); else n_pass++;
                    n_checks++; if (k != e.lat) $display("FAIL b2b_latency got=%0d exp=%0d", k, e.lat); else n_pass++;
                end
            end
            if (k == 2) rs1_i = 64'd9;
            if (k == 4) start_i = 1'b0;
        end
        n_checks++; if (n_done != 2) $display("FAIL b2b_done_count got=%0d exp=2", n_done); else n_pass++;
        sb_q.delete();
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_shortcut();
        test_word();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout got=running exp=finished");
        $fatal(1, "watchdog");
    end

endmodule
